udp_tx_packetizer: RTL and testbench

Transmit-side framer for the UDP stack. It collects a user byte stream (AXI-Stream, 8-bit) into a single-packet store-and-forward buffer. Once a packet closes, it drives the UDP header plus payload interface of the UDP/IP core, which fills in the Ethernet, IP and ARP fields. It sits between user logic and the UDP input port of the stack and is configured from the Ethernet CSR block (local IP) plus its own destination config.

---
 rtl/udp_tx_packetizer.sv | 179 +++++++++++++++++
 tb/tb_udp_tx_packetizer.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_packetizer.sv
// Single-packet store-and-forward UDP transmit framer: buffers a user byte stream, then emits header + payload.
// Optional idle-flush of a partial packet is enabled with `define UDP_TX_FLUSH_TIMEOUT_EN.
`timescale 1ns/1ps
module udp_tx_packetizer #(
    parameter int MAX_PAYLOAD    = 1472,
    parameter int CNT_WIDTH      = 11,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic [31:0] cfg_src_ip,
    input  logic [31:0] cfg_dst_ip,
    input  logic [15:0] cfg_src_port,
    input  logic [15:0] cfg_dst_port,
    input  logic [7:0]  cfg_ttl,
    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [5:0]  m_udp_ip_dscp,
    output logic [1:0]  m_udp_ip_ecn,
    output logic [7:0]  m_udp_ip_ttl,
    output logic [31:0] m_udp_ip_source_ip,
    output logic [31:0] m_udp_ip_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [15:0] m_udp_checksum,
    output logic [7:0]  m_udp_payload_axis_tdata,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,
    output logic [15:0] pkt_sent
);

    typedef enum logic [1:0] {FILL, HDR, PAYLOAD} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(MAX_PAYLOAD - 1);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [7:0]           mem_q [MAX_PAYLOAD];
    logic [CNT_WIDTH-1:0] count_q, count_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]           dout_q, dout_d;
    logic [15:0]          pkt_sent_q, len_q;
    logic [31:0]          src_ip_q, dst_ip_q;
    logic [15:0]          src_port_q, dst_port_q;
    logic [7:0]           ttl_q;
    logic                 accept, close, flush, hdr_fire, pay_fire, pay_last;

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign hdr_fire = m_udp_hdr_valid && m_udp_hdr_ready;
    assign pay_fire = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready;
    assign pay_last = (rd_ptr_q == count_q - ONE);
    // A full buffer closes the packet like tlast; the following byte opens the next one.
    assign close    = (accept && (s_axis_tlast || count_q == LAST_IDX)) || flush;

`ifdef UDP_TX_FLUSH_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;

    assign flush = (state_q == FILL) && !accept && (count_q != '0) &&
                   (idle_q == IDLE_W'(TIMEOUT_CYCLES));

    always_comb begin
        idle_d = '0;
        if (state_q == FILL && !accept && count_q != '0 && !flush)
            idle_d = idle_q + IDLE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (close) state_d = HDR;
            HDR:     if (m_udp_hdr_ready) state_d = PAYLOAD;
            PAYLOAD: if (m_udp_payload_axis_tready && pay_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_axis_tready             = 1'b0;
        m_udp_hdr_valid           = 1'b0;
        m_udp_payload_axis_tvalid = 1'b0;
        m_udp_payload_axis_tlast  = 1'b0;
        case (state_q)
            FILL:    s_axis_tready = !rst;
            HDR:     m_udp_hdr_valid = 1'b1;
            PAYLOAD: begin
                m_udp_payload_axis_tvalid = 1'b1;
                m_udp_payload_axis_tlast  = pay_last;
            end
            default: ;
        endcase
    end

    // Read data is registered one beat ahead so the buffer maps onto synchronous RAM.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (accept) count_d = count_q + ONE;
        if (hdr_fire) begin
            rd_ptr_d = '0;
            dout_d   = mem_q[0];
        end
        if (pay_fire) begin
            if (pay_last) begin
                count_d  = '0;
                rd_ptr_d = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + ONE;
                dout_d   = mem_q[rd_ptr_q + ONE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[count_q] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            dout_q     <= '0;
            pkt_sent_q <= '0;
            len_q      <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            ttl_q      <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            if (close) begin
                len_q      <= 16'(count_d) + 16'd8;
                src_ip_q   <= cfg_src_ip;
                dst_ip_q   <= cfg_dst_ip;
                src_port_q <= cfg_src_port;
                dst_port_q <= cfg_dst_port;
                ttl_q      <= cfg_ttl;
            end
            if (pay_fire && pay_last) pkt_sent_q <= pkt_sent_q + 16'd1;
        end
    end

    assign m_udp_ip_dscp            = '0;
    assign m_udp_ip_ecn             = '0;
    assign m_udp_ip_ttl             = ttl_q;
    assign m_udp_ip_source_ip       = src_ip_q;
    assign m_udp_ip_dest_ip         = dst_ip_q;
    assign m_udp_source_port        = src_port_q;
    assign m_udp_dest_port          = dst_port_q;
    assign m_udp_length             = len_q;
    assign m_udp_checksum           = '0;
    assign m_udp_payload_axis_tdata = dout_q;
    assign m_udp_payload_axis_tuser = 1'b0;
    assign pkt_sent                 = pkt_sent_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Scoreboard bench for udp_tx_packetizer: expected bytes/lengths queued at drive time, popped on DUT output.
`timescale 1ns/1ps
module tb_udp_tx_packetizer;

    localparam int MAXP = 1472;
    localparam int TMO  = 16;
    localparam logic [31:0] SRC_IP = 32'h0A00_0001;
    localparam logic [31:0] DST_IP = 32'h0A00_0002;
    localparam logic [15:0] SPORT  = 16'd1234;
    localparam logic [7:0]  TTL    = 8'd64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic [15:0] cfg_dst_port = 16'd5000;
    logic        m_udp_hdr_valid, m_udp_hdr_ready = 1'b0;
    logic [5:0]  m_udp_ip_dscp;
    logic [1:0]  m_udp_ip_ecn;
    logic [7:0]  m_udp_ip_ttl;
    logic [31:0] m_udp_ip_source_ip, m_udp_ip_dest_ip;
    logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
    logic [7:0]  m_udp_payload_axis_tdata;
    logic        m_udp_payload_axis_tvalid, m_udp_payload_axis_tready = 1'b0;
    logic        m_udp_payload_axis_tlast, m_udp_payload_axis_tuser;
    logic [15:0] pkt_sent;

    int checks = 0, errors = 0, exp_sent = 0, stall_viol = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] len_q[$];
    logic [8:0]  got_q[$];
    logic        have_held = 1'b0;
    logic [8:0]  held = '0;

    udp_tx_packetizer #(.MAX_PAYLOAD(MAXP), .CNT_WIDTH(11), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .cfg_src_ip(SRC_IP), .cfg_dst_ip(DST_IP), .cfg_src_port(SPORT),
        .cfg_dst_port(cfg_dst_port), .cfg_ttl(TTL),
        .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
        .m_udp_ip_dscp(m_udp_ip_dscp), .m_udp_ip_ecn(m_udp_ip_ecn),
        .m_udp_ip_ttl(m_udp_ip_ttl), .m_udp_ip_source_ip(m_udp_ip_source_ip),
        .m_udp_ip_dest_ip(m_udp_ip_dest_ip), .m_udp_source_port(m_udp_source_port),
        .m_udp_dest_port(m_udp_dest_port), .m_udp_length(m_udp_length),
        .m_udp_checksum(m_udp_checksum),
        .m_udp_payload_axis_tdata(m_udp_payload_axis_tdata),
        .m_udp_payload_axis_tvalid(m_udp_payload_axis_tvalid),
        .m_udp_payload_axis_tready(m_udp_payload_axis_tready),
        .m_udp_payload_axis_tlast(m_udp_payload_axis_tlast),
        .m_udp_payload_axis_tuser(m_udp_payload_axis_tuser),
        .pkt_sent(pkt_sent)
    );

    function automatic logic [143:0] hdr_now();
        return {m_udp_ip_source_ip, m_udp_ip_dest_ip, m_udp_source_port, m_udp_dest_port,
                m_udp_ip_ttl, m_udp_length, m_udp_checksum, m_udp_ip_dscp, m_udp_ip_ecn};
    endfunction

    function automatic logic [143:0] hdr_exp(input logic [15:0] len, input logic [15:0] dport);
        return {SRC_IP, DST_IP, SPORT, dport, TTL, len, 16'h0, 6'h0, 2'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        while (!s_axis_tready && n < 5000) begin
            tick();
            n++;
        end
        ok = s_axis_tready;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_hdr(output bit ok);
        int n = 0;
        while (!m_udp_hdr_valid && n < 5000) begin
            tick();
            n++;
        end
        ok = m_udp_hdr_valid;
    endtask

    task automatic hdr_accept();
        m_udp_hdr_ready = 1'b1;
        tick();
        m_udp_hdr_ready = 1'b0;
    endtask

    // One payload handshake under random ready; also tallies any change of a stalled beat.
    task automatic take_beat(input int pct, output logic [8:0] beat, output bit ok);
        ok   = 1'b0;
        beat = '0;
        for (int n = 0; n < 5000 && !ok; n++) begin
            if (have_held && (!m_udp_payload_axis_tvalid ||
                {m_udp_payload_axis_tlast, m_udp_payload_axis_tdata} !== held))
                stall_viol++;
            have_held = 1'b0;
            m_udp_payload_axis_tready = ($urandom_range(0, 99) < pct);
            if (m_udp_payload_axis_tvalid) begin
                if (m_udp_payload_axis_tready) begin
                    beat = {m_udp_payload_axis_tlast, m_udp_payload_axis_tdata};
                    ok   = 1'b1;
                end else begin
                    have_held = 1'b1;
                    held      = {m_udp_payload_axis_tlast, m_udp_payload_axis_tdata};
                end
            end
            tick();
        end
    endtask

    task automatic recv_packet(input int pct, output bit ok);
        logic [8:0] b;
        bit bok;
        got_q.delete();
        have_held = 1'b0;
        ok = 1'b0;
        for (int i = 0; i <= MAXP; i++) begin
            take_beat(pct, b, bok);
            if (!bok) break;
            got_q.push_back(b);
            if (b[8]) begin
                ok = 1'b1;
                break;
            end
        end
        m_udp_payload_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast, s_axis_tready, pkt_sent} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got hv=%b pv=%b pl=%b rdy=%b sent=%0d required all 0",
                     m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast, s_axis_tready, pkt_sent);
        end
        checks++;
        if ({hdr_now(), m_udp_payload_axis_tdata} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got %h data %h required 0", hdr_now(), m_udp_payload_axis_tdata);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b required 1", s_axis_tready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] pl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [8:0] e;
        bit sok = 1'b1, ok, hok, rok;
        len_q.push_back(16'd12);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back({i == 3, pl[i]});
                    send_byte(pl[i], i == 3, ok);
                    sok &= ok;
                end
            end
            begin
                wait_hdr(hok);
                checks++;
                e[0] = 1'b0;
                if (!hok || hdr_now() !== hdr_exp(len_q.pop_front(), cfg_dst_port)) begin
                    errors++;
                    $display("FAIL basic_hdr: got valid=%b hdr=%h required %h", hok, hdr_now(), hdr_exp(16'd12, cfg_dst_port));
                end
                hdr_accept();
                checks++;
                if (m_udp_hdr_valid !== 1'b0 || m_udp_payload_axis_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_first_beat: got hv=%b pv=%b required 0/1", m_udp_hdr_valid, m_udp_payload_axis_tvalid);
                end
                recv_packet(100, rok);
            end
        join
        checks++;
        if (!sok || !rok || got_q.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got send_ok=%b recv_ok=%b beats=%0d required 1/1/4", sok, rok, got_q.size());
        end
        foreach (got_q[i]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h required %h", i, got_q[i], e);
            end
        end
        exp_sent++;
        checks++;
        if (pkt_sent !== 16'(exp_sent)) begin
            errors++;
            $display("FAIL basic_pkt_sent: got %0d required %0d", pkt_sent, exp_sent);
        end
        exp_q.delete();
    endtask

    task automatic test_split();
        logic [8:0] e;
        logic [15:0] el;
        bit sok = 1'b1, ok, hok, rok;
        int bad = 0;
        len_q.push_back(16'(MAXP + 8));
        len_q.push_back(16'(1500 - MAXP + 8));
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    exp_q.push_back({(i == MAXP - 1) || (i == 1499), 8'(i * 7 + 3)});
                    send_byte(8'(i * 7 + 3), i == 1499, ok);
                    sok &= ok;
                end
            end
            begin
                for (int p = 0; p < 2; p++) begin
                    wait_hdr(hok);
                    el = len_q.pop_front();
                    checks++;
                    if (!hok || m_udp_length !== el) begin
                        errors++;
                        $display("FAIL split_len%0d: got valid=%b len=%0d required %0d", p, hok, m_udp_length, el);
                    end
                    if (!hok) break;
                    hdr_accept();
                    recv_packet(70, rok);
                    bad = 0;
                    foreach (got_q[i]) begin
                        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
                        if (got_q[i] !== e) bad++;
                    end
                    checks++;
                    if (!rok || got_q.size() != int'(el) - 8 || bad != 0) begin
                        errors++;
                        $display("FAIL split_payload%0d: got beats=%0d wrong=%0d required %0d/0", p, got_q.size(), bad, el - 8);
                    end
                    exp_sent++;
                end
            end
        join
        checks++;
        if (!sok || pkt_sent !== 16'(exp_sent) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL split_done: got send_ok=%b sent=%0d left=%0d required 1/%0d/0", sok, pkt_sent, exp_q.size(), exp_sent);
        end
        exp_q.delete();
    endtask

    task automatic test_hdr_stall();
        logic [8:0] e;
        bit sok = 1'b1, ok, hok, rok;
        int bad = 0;
        fork
            begin
                exp_q.push_back({1'b0, 8'hA5});
                send_byte(8'hA5, 1'b0, ok);
                sok &= ok;
                exp_q.push_back({1'b1, 8'h5A});
                send_byte(8'h5A, 1'b1, ok);
                sok &= ok;
            end
            begin
                wait_hdr(hok);
                tick();
                s_axis_tdata  = 8'hEE;
                s_axis_tvalid = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    if (m_udp_hdr_valid !== 1'b1 || s_axis_tready !== 1'b0 || hdr_now() !== hdr_exp(16'd10, cfg_dst_port)) bad++;
                    tick();
                end
                s_axis_tvalid = 1'b0;
                checks++;
                if (!hok || bad != 0) begin
                    errors++;
                    $display("FAIL hdr_stall: got valid=%b unstable_cycles=%0d hdr=%h required 1/0/%h", hok, bad, hdr_now(), hdr_exp(16'd10, cfg_dst_port));
                end
                hdr_accept();
                recv_packet(100, rok);
            end
        join
        checks++;
        if (!sok || !rok || got_q.size() != 2) begin
            errors++;
            $display("FAIL stall_count: got beats=%0d required 2", got_q.size());
        end
        foreach (got_q[i]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h required %h", i, got_q[i], e);
            end
        end
        exp_sent++;
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [8:0] e;
        bit sok = 1'b1, ok, hok, rok;
        int bad = 0;
        stall_viol = 0;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    exp_q.push_back({i == 63, 8'($urandom)});
                    send_byte(exp_q[i][7:0], i == 63, ok);
                    sok &= ok;
                end
            end
            begin
                wait_hdr(hok);
                checks++;
                if (!hok || m_udp_length !== 16'd72) begin
                    errors++;
                    $display("FAIL bp_len: got valid=%b len=%0d required 72", hok, m_udp_length);
                end
                hdr_accept();
                recv_packet(50, rok);
            end
        join
        foreach (got_q[i]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
            if (got_q[i] !== e) bad++;
        end
        checks++;
        if (!sok || !rok || got_q.size() != 64 || bad != 0) begin
            errors++;
            $display("FAIL bp_payload: got beats=%0d wrong=%0d required 64/0", got_q.size(), bad);
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d changes while stalled required 0", stall_viol);
        end
        exp_sent++;
        checks++;
        if (pkt_sent !== 16'(exp_sent)) begin
            errors++;
            $display("FAIL bp_pkt_sent: got %0d required %0d", pkt_sent, exp_sent);
        end
        exp_q.delete();
    endtask

    task automatic test_cfg_change();
        bit ok, hok, rok;
        cfg_dst_port = 16'd5000;
        for (int p = 0; p < 2; p++) begin
            fork
                send_byte(8'h7E + 8'(p), 1'b1, ok);
                begin
                    wait_hdr(hok);
                    cfg_dst_port = 16'd6000;
                    repeat (3) tick();
                    checks++;
                    if (!hok || hdr_now() !== hdr_exp(16'd9, (p == 0) ? 16'd5000 : 16'd6000)) begin
                        errors++;
                        $display("FAIL cfg_pkt%0d: got valid=%b dport=%0d required %0d", p, hok, m_udp_dest_port, (p == 0) ? 5000 : 6000);
                    end
                    hdr_accept();
                    recv_packet(100, rok);
                end
            join
            checks++;
            if (!ok || !rok || got_q.size() != 1 || got_q[0] !== {1'b1, 8'h7E + 8'(p)}) begin
                errors++;
                $display("FAIL cfg_payload%0d: got beats=%0d first=%h required 1/%h", p, got_q.size(), (got_q.size() != 0) ? got_q[0] : 9'h0, {1'b1, 8'h7E + 8'(p)});
            end
            exp_sent++;
        end
        cfg_dst_port = 16'd5000;
    endtask

    task automatic test_flush();
        logic [8:0] e;
        bit sok = 1'b1, ok, hok, rok;
        int n = 0;
        for (int i = 0; i < 3; i++) begin
`ifdef UDP_TX_FLUSH_TIMEOUT_EN
            exp_q.push_back({i == 2, 8'(i + 1)});
`else
            exp_q.push_back({1'b0, 8'(i + 1)});
`endif
            send_byte(8'(i + 1), 1'b0, ok);
            sok &= ok;
        end
`ifdef UDP_TX_FLUSH_TIMEOUT_EN
        while (!m_udp_hdr_valid && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!m_udp_hdr_valid || n != TMO + 1 || m_udp_length !== 16'd11) begin
            errors++;
            $display("FAIL flush_hdr: got valid=%b after %0d cycles len=%0d required 1/%0d/11", m_udp_hdr_valid, n, m_udp_length, TMO + 1);
        end
        hok = m_udp_hdr_valid;
`else
        for (int c = 0; c < 100; c++) begin
            if (m_udp_hdr_valid) n++;
            tick();
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL no_flush: got header for %0d cycles required 0", n);
        end
        exp_q.push_back({1'b1, 8'h04});
        send_byte(8'h04, 1'b1, ok);
        sok &= ok;
        wait_hdr(hok);
        checks++;
        if (!hok || m_udp_length !== 16'd12) begin
            errors++;
            $display("FAIL tail_len: got valid=%b len=%0d required 12", hok, m_udp_length);
        end
`endif
        hdr_accept();
        recv_packet(100, rok);
        checks++;
        if (!sok || !hok || !rok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL flush_count: got beats=%0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (got_q[i]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL flush_beat%0d: got %h required %h", i, got_q[i], e);
            end
        end
        exp_sent++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [8:0] b;
        bit ok, hok, rok;
        for (int i = 0; i < 3; i++) send_byte(8'h31 + 8'(i), i == 2, ok);
        wait_hdr(hok);
        hdr_accept();
        take_beat(100, b, ok);
        m_udp_payload_axis_tready = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        exp_sent = 0;
        checks++;
        if (m_udp_hdr_valid !== 1'b0 || m_udp_payload_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || pkt_sent !== 16'd0) begin
            errors++;
            $display("FAIL midreset_state: got hv=%b pv=%b rdy=%b sent=%0d required 0/0/1/0", m_udp_hdr_valid, m_udp_payload_axis_tvalid, s_axis_tready, pkt_sent);
        end
        send_byte(8'h99, 1'b1, ok);
        wait_hdr(hok);
        checks++;
        if (!hok || m_udp_length !== 16'd9) begin
            errors++;
            $display("FAIL midreset_len: got valid=%b len=%0d required 9", hok, m_udp_length);
        end
        hdr_accept();
        recv_packet(100, rok);
        exp_sent++;
        checks++;
        if (!rok || got_q.size() != 1 || got_q[0] !== 9'h199 || pkt_sent !== 16'(exp_sent)) begin
            errors++;
            $display("FAIL midreset_payload: got beats=%0d first=%h sent=%0d required 1/199/%0d", got_q.size(), (got_q.size() != 0) ? got_q[0] : 9'h0, pkt_sent, exp_sent);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_split();
        test_hdr_stall();
        test_backpressure();
        test_cfg_change();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
